// File: rtl/id_exe_buf_if.sv
// Handshake and payload bundle between decode, the id_exe_buf skid register
// and the execute stage, including the write-back forwarding port.
interface id_exe_buf_if #(
   parameter int XLEN  = 64,
   parameter int OP_W  = 8,
   parameter int ALU_W = 12
);
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  in_pc;
   logic [XLEN-1:0]  in_op1;
   logic [XLEN-1:0]  in_op2;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rs2;
   logic             in_op1_is_reg;
   logic             in_op2_is_reg;
   logic [OP_W-1:0]  in_op_info;
   logic [ALU_W-1:0] in_alu_info;
   logic             in_word;
   logic [4:0]       in_rd;
   logic             in_rd_wen;

   logic             flush;

   logic             fwd_wen;
   logic [4:0]       fwd_rd;
   logic [XLEN-1:0]  fwd_data;

   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [XLEN-1:0]  out_op1;
   logic [XLEN-1:0]  out_op2;
   logic [OP_W-1:0]  out_op_info;
   logic [ALU_W-1:0] out_alu_info;
   logic             out_word;
   logic [4:0]       out_rd;
   logic             out_rd_wen;

   // Environment side: decode, flush source, write-back and execute
   modport master (
      output in_valid, in_pc, in_op1, in_op2, in_rs1, in_rs2,
             in_op1_is_reg, in_op2_is_reg, in_op_info, in_alu_info,
             in_word, in_rd, in_rd_wen,
             flush, fwd_wen, fwd_rd, fwd_data, out_ready,
      input  in_ready, out_valid, out_pc, out_op1, out_op2, out_op_info,
             out_alu_info, out_word, out_rd, out_rd_wen
   );

   // Buffer side
   modport slave (
      input  in_valid, in_pc, in_op1, in_op2, in_rs1, in_rs2,
             in_op1_is_reg, in_op2_is_reg, in_op_info, in_alu_info,
             in_word, in_rd, in_rd_wen,
             flush, fwd_wen, fwd_rd, fwd_data, out_ready,
      output in_ready, out_valid, out_pc, out_op1, out_op2, out_op_info,
             out_alu_info, out_word, out_rd, out_rd_wen
   );
endinterface

// File: rtl/id_exe_buf.sv
// Two-entry skid-buffered decode->execute pipeline register. The main entry
// always holds the oldest instruction and drives execute; the skid entry
// absorbs one extra instruction so in_ready can stay registered. Held
// register operands are patched with write-back data every cycle.
module id_exe_buf #(
   parameter int XLEN  = 64,
   parameter int OP_W  = 8,
   parameter int ALU_W = 12
) (
   input logic          clk,
   input logic          rst,
   id_exe_buf_if.slave  bus
);

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } state_t;

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  op1;
      logic [XLEN-1:0]  op2;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic             op1_is_reg;
      logic             op2_is_reg;
      logic [OP_W-1:0]  op_info;
      logic [ALU_W-1:0] alu_info;
      logic             word;
      logic [4:0]       rd;
      logic             rd_wen;
   } entry_t;

   state_t state;
   entry_t main_q;
   entry_t skid_q;
   logic   main_valid;
   logic   skid_valid;
   logic   in_ready_q;

   entry_t in_fwd;
   entry_t main_fwd;
   entry_t skid_fwd;
   logic   accept;
   logic   issue;

   // An operand picks up write-back data only if it really came from the
   // register file and names the register being written; x0 never forwards.
   function automatic logic fwd_hit(input logic [4:0] rs, input logic is_reg);
      return bus.fwd_wen && (bus.fwd_rd != 5'd0) && (bus.fwd_rd == rs) && is_reg;
   endfunction

   assign accept = bus.in_valid & in_ready_q;
   assign issue  = main_valid & bus.out_ready;

   // Candidate entry values with write-back already applied: the incoming
   // instruction, and both held entries (only while they are valid)
   always_comb begin
      in_fwd.pc         = bus.in_pc;
      in_fwd.op1        = bus.in_op1;
      in_fwd.op2        = bus.in_op2;
      in_fwd.rs1        = bus.in_rs1;
      in_fwd.rs2        = bus.in_rs2;
      in_fwd.op1_is_reg = bus.in_op1_is_reg;
      in_fwd.op2_is_reg = bus.in_op2_is_reg;
      in_fwd.op_info    = bus.in_op_info;
      in_fwd.alu_info   = bus.in_alu_info;
      in_fwd.word       = bus.in_word;
      in_fwd.rd         = bus.in_rd;
      in_fwd.rd_wen     = bus.in_rd_wen;
      if (fwd_hit(bus.in_rs1, bus.in_op1_is_reg)) in_fwd.op1 = bus.fwd_data;
      if (fwd_hit(bus.in_rs2, bus.in_op2_is_reg)) in_fwd.op2 = bus.fwd_data;

      main_fwd = main_q;
      if (main_valid && fwd_hit(main_q.rs1, main_q.op1_is_reg)) main_fwd.op1 = bus.fwd_data;
      if (main_valid && fwd_hit(main_q.rs2, main_q.op2_is_reg)) main_fwd.op2 = bus.fwd_data;

      skid_fwd = skid_q;
      if (skid_valid && fwd_hit(skid_q.rs1, skid_q.op1_is_reg)) skid_fwd.op1 = bus.fwd_data;
      if (skid_valid && fwd_hit(skid_q.rs2, skid_q.op2_is_reg)) skid_fwd.op2 = bus.fwd_data;
   end

   // Occupancy FSM plus entry storage; flush outranks every transition and
   // in_ready is registered as the inverse of the next skid valid
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         main_q <= main_fwd;
         skid_q <= skid_fwd;
         if (bus.flush) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready_q <= 1'b1;
         end else begin
            case (state)
               EMPTY: begin
                  in_ready_q <= 1'b1;
                  if (accept) begin
                     main_q     <= in_fwd;
                     main_valid <= 1'b1;
                     state      <= ONE;
                  end
               end
               ONE: begin
                  if (accept && issue) begin
                     main_q     <= in_fwd;
                     in_ready_q <= 1'b1;
                  end else if (accept) begin
                     skid_q     <= in_fwd;
                     skid_valid <= 1'b1;
                     in_ready_q <= 1'b0;
                     state      <= FULL;
                  end else if (issue) begin
                     main_valid <= 1'b0;
                     in_ready_q <= 1'b1;
                     state      <= EMPTY;
                  end else begin
                     in_ready_q <= 1'b1;
                  end
               end
               FULL: begin
                  if (issue) begin
                     main_q     <= skid_fwd;
                     skid_valid <= 1'b0;
                     in_ready_q <= 1'b1;
                     state      <= ONE;
                  end else begin
                     in_ready_q <= 1'b0;
                  end
               end
               default: begin
                  state      <= EMPTY;
                  main_valid <= 1'b0;
                  skid_valid <= 1'b0;
                  in_ready_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.out_valid    = main_valid;
   assign bus.out_pc       = main_q.pc;
   assign bus.out_op1      = main_q.op1;
   assign bus.out_op2      = main_q.op2;
   assign bus.out_op_info  = main_q.op_info;
   assign bus.out_alu_info = main_q.alu_info;
   assign bus.out_word     = main_q.word;
   assign bus.out_rd       = main_q.rd;
   assign bus.out_rd_wen   = main_q.rd_wen & main_valid;

endmodule

// File: tb/tb_id_exe_buf.sv
// Directed self-checking bench for id_exe_buf: streaming, back-pressure,
// operand forwarding (held, captured, skid), flush and mid-transfer reset.
module tb_id_exe_buf;

   logic clk;
   logic rst;
   int   numChecks;
   int   numErrors;

   id_exe_buf_if #(.XLEN(64), .OP_W(8), .ALU_W(12)) bus ();

   id_exe_buf #(.XLEN(64), .OP_W(8), .ALU_W(12)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      numChecks++;
      if (got !== exp) begin
         numErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one decode instruction; control fields are derived from the pc
   task automatic applyStimulus(input logic valid, input logic [63:0] pc);
      bus.in_valid    = valid;
      bus.in_pc       = pc;
      bus.in_op_info  = pc[7:0];
      bus.in_alu_info = 12'h001 << pc[3:2];
      bus.in_word     = pc[2];
      bus.in_rd       = pc[6:2];
      bus.in_rd_wen   = 1'b1;
   endtask

   // Advance one clock and settle just after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clearOperands();
      bus.in_op1        = 64'h0;
      bus.in_op2        = 64'h0;
      bus.in_rs1        = 5'd0;
      bus.in_rs2        = 5'd0;
      bus.in_op1_is_reg = 1'b0;
      bus.in_op2_is_reg = 1'b0;
   endtask

   task automatic doFlush();
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
   endtask

   initial begin
      numChecks = 0;
      numErrors = 0;
      rst = 1'b1;
      applyStimulus(1'b0, 64'h0);
      clearOperands();
      bus.flush     = 1'b0;
      bus.fwd_wen   = 1'b0;
      bus.fwd_rd    = 5'd0;
      bus.fwd_data  = 64'h0;
      bus.out_ready = 1'b0;

      // Reset state
      step();
      step();
      checkOutput("rst_out_valid", {63'b0, bus.out_valid}, 64'h0);
      checkOutput("rst_in_ready", {63'b0, bus.in_ready}, 64'h0);
      checkOutput("rst_rd_wen", {63'b0, bus.out_rd_wen}, 64'h0);
      checkOutput("rst_pc", bus.out_pc, 64'h0);
      checkOutput("rst_op1", bus.out_op1, 64'h0);
      rst = 1'b0;
      step();
      checkOutput("post_rst_in_ready", {63'b0, bus.in_ready}, 64'h1);

      // Streaming at full rate
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 64'h8000_0000 + 64'(4 * i));
         step();
         checkOutput("stream_valid", {63'b0, bus.out_valid}, 64'h1);
         checkOutput("stream_pc", bus.out_pc, 64'h8000_0000 + 64'(4 * i));
         checkOutput("stream_in_ready", {63'b0, bus.in_ready}, 64'h1);
      end
      checkOutput("stream_op_info", {56'b0, bus.out_op_info}, 64'h0C);
      checkOutput("stream_alu_info", {52'b0, bus.out_alu_info}, 64'h008);
      checkOutput("stream_word", {63'b0, bus.out_word}, 64'h1);
      checkOutput("stream_rd", {59'b0, bus.out_rd}, 64'h03);
      applyStimulus(1'b0, 64'h0);
      step();
      checkOutput("stream_drain_valid", {63'b0, bus.out_valid}, 64'h0);
      checkOutput("stream_drain_rd_wen", {63'b0, bus.out_rd_wen}, 64'h0);

      // Back-pressure fills main then skid
      bus.out_ready = 1'b0;
      applyStimulus(1'b1, 64'h100);
      step();
      checkOutput("bp_first_pc", bus.out_pc, 64'h100);
      checkOutput("bp_first_in_ready", {63'b0, bus.in_ready}, 64'h1);
      applyStimulus(1'b1, 64'h104);
      step();
      checkOutput("bp_full_in_ready", {63'b0, bus.in_ready}, 64'h0);
      checkOutput("bp_full_pc", bus.out_pc, 64'h100);
      applyStimulus(1'b1, 64'h108);
      step();
      checkOutput("bp_hold_pc", bus.out_pc, 64'h100);
      checkOutput("bp_hold_in_ready", {63'b0, bus.in_ready}, 64'h0);
      applyStimulus(1'b0, 64'h0);
      bus.out_ready = 1'b1;
      step();
      checkOutput("bp_issue1_pc", bus.out_pc, 64'h104);
      checkOutput("bp_issue1_in_ready", {63'b0, bus.in_ready}, 64'h1);
      step();
      checkOutput("bp_issue2_valid", {63'b0, bus.out_valid}, 64'h0);

      // Forward onto a held main entry
      bus.out_ready = 1'b0;
      applyStimulus(1'b1, 64'h300);
      bus.in_rs1 = 5'd5;
      bus.in_op1 = 64'h11;
      bus.in_op1_is_reg = 1'b1;
      step();
      checkOutput("fwd_held_before", bus.out_op1, 64'h11);
      applyStimulus(1'b0, 64'h0);
      bus.fwd_wen  = 1'b1;
      bus.fwd_rd   = 5'd5;
      bus.fwd_data = 64'hDEAD;
      step();
      checkOutput("fwd_held_after", bus.out_op1, 64'hDEAD);
      bus.fwd_wen = 1'b0;
      doFlush();

      // x0 never forwards
      applyStimulus(1'b1, 64'h310);
      bus.in_rs1 = 5'd0;
      step();
      applyStimulus(1'b0, 64'h0);
      bus.fwd_wen = 1'b1;
      bus.fwd_rd  = 5'd0;
      step();
      checkOutput("fwd_x0", bus.out_op1, 64'h11);
      bus.fwd_wen = 1'b0;
      doFlush();

      // Non-register operand never forwards
      applyStimulus(1'b1, 64'h320);
      bus.in_rs1 = 5'd5;
      bus.in_op1_is_reg = 1'b0;
      step();
      applyStimulus(1'b0, 64'h0);
      bus.fwd_wen = 1'b1;
      bus.fwd_rd  = 5'd5;
      step();
      checkOutput("fwd_not_reg", bus.out_op1, 64'h11);
      bus.fwd_wen = 1'b0;
      doFlush();
      checkOutput("flush_empty", {63'b0, bus.out_valid}, 64'h0);
      clearOperands();

      // Forward on capture
      applyStimulus(1'b1, 64'h400);
      bus.in_rs2 = 5'd7;
      bus.in_op2 = 64'h22;
      bus.in_op2_is_reg = 1'b1;
      bus.fwd_wen  = 1'b1;
      bus.fwd_rd   = 5'd7;
      bus.fwd_data = 64'hBEEF;
      step();
      checkOutput("fwd_capture_valid", {63'b0, bus.out_valid}, 64'h1);
      checkOutput("fwd_capture_op2", bus.out_op2, 64'hBEEF);

      // Forward onto the skid entry, then promote it to main
      bus.fwd_wen = 1'b0;
      clearOperands();
      applyStimulus(1'b1, 64'h404);
      bus.in_rs1 = 5'd9;
      bus.in_op1 = 64'h1;
      bus.in_op1_is_reg = 1'b1;
      step();
      applyStimulus(1'b0, 64'h0);
      bus.fwd_wen  = 1'b1;
      bus.fwd_rd   = 5'd9;
      bus.fwd_data = 64'h55;
      step();
      bus.fwd_wen   = 1'b0;
      bus.out_ready = 1'b1;
      step();
      checkOutput("fwd_skid_pc", bus.out_pc, 64'h404);
      checkOutput("fwd_skid_op1", bus.out_op1, 64'h55);
      bus.out_ready = 1'b0;
      clearOperands();

      // Flush in FULL with decode offering 0x200
      applyStimulus(1'b1, 64'h1FC);
      step();
      checkOutput("flush_full_in_ready", {63'b0, bus.in_ready}, 64'h0);
      applyStimulus(1'b1, 64'h200);
      bus.flush = 1'b1;
      step();
      checkOutput("flush_full_valid", {63'b0, bus.out_valid}, 64'h0);
      checkOutput("flush_full_in_ready_after", {63'b0, bus.in_ready}, 64'h1);
      bus.flush = 1'b0;
      applyStimulus(1'b0, 64'h0);
      step();
      checkOutput("flush_full_no_200", {63'b0, bus.out_valid}, 64'h0);

      // Flush discards an instruction accepted in the same cycle
      applyStimulus(1'b1, 64'h500);
      step();
      applyStimulus(1'b1, 64'h504);
      bus.flush = 1'b1;
      step();
      checkOutput("flush_accept_valid", {63'b0, bus.out_valid}, 64'h0);
      bus.flush = 1'b0;
      applyStimulus(1'b0, 64'h0);
      step();
      checkOutput("flush_accept_dropped", {63'b0, bus.out_valid}, 64'h0);

      // Synchronous reset while FULL
      applyStimulus(1'b1, 64'h600);
      bus.in_op1 = 64'h77;
      step();
      applyStimulus(1'b1, 64'h604);
      step();
      checkOutput("rst_full_in_ready", {63'b0, bus.in_ready}, 64'h0);
      checkOutput("rst_full_op1", bus.out_op1, 64'h77);
      rst = 1'b1;
      applyStimulus(1'b0, 64'h0);
      step();
      checkOutput("rst_mid_valid", {63'b0, bus.out_valid}, 64'h0);
      checkOutput("rst_mid_rd_wen", {63'b0, bus.out_rd_wen}, 64'h0);
      checkOutput("rst_mid_op1", bus.out_op1, 64'h0);
      checkOutput("rst_mid_pc", bus.out_pc, 64'h0);
      checkOutput("rst_mid_in_ready", {63'b0, bus.in_ready}, 64'h0);
      step();
      checkOutput("rst_hold_in_ready", {63'b0, bus.in_ready}, 64'h0);
      rst = 1'b0;
      step();
      checkOutput("rst_release_in_ready", {63'b0, bus.in_ready}, 64'h1);
      checkOutput("rst_release_valid", {63'b0, bus.out_valid}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule
